// File: rtl/ahb_lite_gpio_irq.sv
// ahb_lite_gpio_irq: AHB-Lite slave GPIO bank with edge interrupts.
//
// PORT_NUM ports of PORT_WIDTH pins. Each port occupies 0x20 bytes:
//   +00 OUT  +04 DIR  +08 IN  +0C SET  +10 CLR  +14 RISE_EN  +18 FALL_EN  +1C STATUS (W1C)
// Pins are driven from OUT where DIR=1 and are synchronised through two flops
// into IN. A third flop gives the previous value for rise/fall detection.
// Decode errors (port index out of range or HADDR above ADDR_WIDTH nonzero)
// produce the two-cycle AHB ERROR response and modify nothing.
//
// Ports:
//   HCLK, HRESET        clock, asynchronous active-high reset
//   HSEL..HREADY        AHB-Lite slave inputs
//   HREADYOUT, HRDATA,
//   HRESP               AHB-Lite slave outputs
//   io_pin              bidirectional pins, port p = [p*PORT_WIDTH +: PORT_WIDTH]
//   irq                 per-port level interrupt, OR of that port's STATUS
module ahb_lite_gpio_irq #(
  parameter int unsigned PORT_NUM   = 4,
  parameter int unsigned PORT_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic                           HSEL,
  input  logic [31:0]                    HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HSIZE,
  input  logic                           HWRITE,
  input  logic [31:0]                    HWDATA,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic [31:0]                    HRDATA,
  output logic                           HRESP,
  inout  wire  [PORT_NUM*PORT_WIDTH-1:0] io_pin,
  output logic [PORT_NUM-1:0]            irq
);

  localparam int unsigned NumPins = PORT_NUM * PORT_WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StErr1 = 2'd1;
  localparam logic [1:0] StErr2 = 2'd2;

  localparam logic [2:0] RegOut  = 3'd0;
  localparam logic [2:0] RegDir  = 3'd1;
  localparam logic [2:0] RegIn   = 3'd2;
  localparam logic [2:0] RegSet  = 3'd3;
  localparam logic [2:0] RegClr  = 3'd4;
  localparam logic [2:0] RegRise = 3'd5;
  localparam logic [2:0] RegFall = 3'd6;
  localparam logic [2:0] RegStat = 3'd7;

  logic [1:0]         state_q, state_d;
  logic               a_valid_q, a_valid_d;
  logic               a_write_q, a_write_d;
  logic [2:0]         a_port_q, a_port_d;
  logic [2:0]         a_reg_q, a_reg_d;
  logic [3:0]         a_be_q, a_be_d;
  logic [NumPins-1:0] out_q, out_d;
  logic [NumPins-1:0] dir_q, dir_d;
  logic [NumPins-1:0] rise_q, rise_d;
  logic [NumPins-1:0] fall_q, fall_d;
  logic [NumPins-1:0] stat_q, stat_d;
  logic [NumPins-1:0] s1_q, s2_q, s3_q;

  // Address-phase decode
  logic [ADDR_WIDTH-1:0] addr_low;
  logic [ADDR_WIDTH-1:0] port_idx;
  logic                  addr_hi_nz;
  logic                  dec_err;
  logic                  access, acc_ok, acc_err;
  logic [3:0]            be;

  assign addr_low   = HADDR[ADDR_WIDTH-1:0];
  assign port_idx   = addr_low >> 5;
  assign addr_hi_nz = (HADDR >> ADDR_WIDTH) != 32'd0;
  assign dec_err    = addr_hi_nz | (32'(port_idx) >= PORT_NUM);

  // No new access is taken while the first error cycle stalls the bus.
  assign access  = HSEL & HREADY & HTRANS[1] & (state_q != StErr1);
  assign acc_ok  = access & ~dec_err;
  assign acc_err = access & dec_err;

  always_comb begin
    case (HSIZE)
      3'd0:    be = 4'b0001 << HADDR[1:0];
      3'd1:    be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Error response sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (acc_err) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = acc_err ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign HREADYOUT = (state_q != StErr1);
  assign HRESP     = (state_q == StErr1) || (state_q == StErr2);

  // Latched data-phase control
  always_comb begin
    a_valid_d = acc_ok;
    a_write_d = a_write_q;
    a_port_d  = a_port_q;
    a_reg_d   = a_reg_q;
    a_be_d    = a_be_q;
    if (acc_ok) begin
      a_write_d = HWRITE;
      a_port_d  = port_idx[2:0];
      a_reg_d   = HADDR[4:2];
      a_be_d    = be;
    end
  end

  // Edge detection on the synchronised inputs
  logic [NumPins-1:0] edge_set;
  assign edge_set = (s2_q & ~s3_q & rise_q) | (~s2_q & s3_q & fall_q);

  // Byte-lane masked write data, truncated to the port width
  logic [31:0]           wmask32;
  logic [PORT_WIDTH-1:0] wd;
  assign wmask32 = {{8{a_be_q[3]}}, {8{a_be_q[2]}}, {8{a_be_q[1]}}, {8{a_be_q[0]}}};
  assign wd      = HWDATA[PORT_WIDTH-1:0] & wmask32[PORT_WIDTH-1:0];

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    rise_d = rise_q;
    fall_d = fall_q;
    // New edges always set; a W1C on the same bit cannot override them.
    stat_d = stat_q | edge_set;
    if (a_valid_q && a_write_q) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (32'(a_port_q) == p) begin
          case (a_reg_q)
            RegOut: out_d[p*PORT_WIDTH +: PORT_WIDTH] =
                (out_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wmask32[PORT_WIDTH-1:0]) | wd;
            RegDir: dir_d[p*PORT_WIDTH +: PORT_WIDTH] =
                (dir_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wmask32[PORT_WIDTH-1:0]) | wd;
            RegSet: out_d[p*PORT_WIDTH +: PORT_WIDTH] =
                out_q[p*PORT_WIDTH +: PORT_WIDTH] | wd;
            RegClr: out_d[p*PORT_WIDTH +: PORT_WIDTH] =
                out_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wd;
            RegRise: rise_d[p*PORT_WIDTH +: PORT_WIDTH] =
                (rise_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wmask32[PORT_WIDTH-1:0]) | wd;
            RegFall: fall_d[p*PORT_WIDTH +: PORT_WIDTH] =
                (fall_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wmask32[PORT_WIDTH-1:0]) | wd;
            RegStat: stat_d[p*PORT_WIDTH +: PORT_WIDTH] =
                (stat_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wd) | edge_set[p*PORT_WIDTH +: PORT_WIDTH];
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux, only meaningful during an OKAY read data phase
  always_comb begin
    HRDATA = '0;
    if (a_valid_q && !a_write_q) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (32'(a_port_q) == p) begin
          case (a_reg_q)
            RegOut:  HRDATA[PORT_WIDTH-1:0] = out_q[p*PORT_WIDTH +: PORT_WIDTH];
            RegDir:  HRDATA[PORT_WIDTH-1:0] = dir_q[p*PORT_WIDTH +: PORT_WIDTH];
            RegIn:   HRDATA[PORT_WIDTH-1:0] = s2_q[p*PORT_WIDTH +: PORT_WIDTH];
            RegRise: HRDATA[PORT_WIDTH-1:0] = rise_q[p*PORT_WIDTH +: PORT_WIDTH];
            RegFall: HRDATA[PORT_WIDTH-1:0] = fall_q[p*PORT_WIDTH +: PORT_WIDTH];
            RegStat: HRDATA[PORT_WIDTH-1:0] = stat_q[p*PORT_WIDTH +: PORT_WIDTH];
            default: HRDATA = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      irq[p] = |stat_q[p*PORT_WIDTH +: PORT_WIDTH];
    end
  end

  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    assign io_pin[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= StIdle;
      a_valid_q <= 1'b0;
      a_write_q <= 1'b0;
      a_port_q  <= '0;
      a_reg_q   <= '0;
      a_be_q    <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      stat_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_valid_q <= a_valid_d;
      a_write_q <= a_write_d;
      a_port_q  <= a_port_d;
      a_reg_q   <= a_reg_d;
      a_be_q    <= a_be_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stat_q    <= stat_d;
      s1_q      <= io_pin;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahb_lite_gpio_irq.sv
// Bench for ahb_lite_gpio_irq: a bus driver pushes the expected response of
// each transfer into a queue; a monitor pops and compares when the data phase
// completes. Pin and irq timing are checked directly.
module tb_ahb_lite_gpio_irq;
  localparam int unsigned PN = 4;
  localparam int unsigned PW = 32;
  localparam int unsigned NP = PN * PW;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd2;
  logic          HWRITE = 1'b0;
  logic [31:0]   HWDATA = '0;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [PN-1:0] irq;
  wire  [NP-1:0] io_pin;

  logic [NP-1:0] tb_oe;
  logic [NP-1:0] tb_val;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] data;
    logic        resp;
    logic [1:0]  waits;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];

  always #5 HCLK = ~HCLK;

  for (genvar i = 0; i < NP; i++) begin : g_drv
    assign io_pin[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  ahb_lite_gpio_irq #(
    .PORT_NUM  (PN),
    .PORT_WIDTH(PW),
    .ADDR_WIDTH(8)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HWRITE   (HWRITE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADYOUT),
    .HREADYOUT(HREADYOUT),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP),
    .io_pin   (io_pin),
    .irq      (irq)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  // Issue one address phase (idle when act=0) and wait until it is accepted.
  task automatic bus(input logic act, input logic [31:0] addr, input logic wr,
                     input logic [2:0] size, input logic [31:0] wd, input logic push,
                     input logic chkd, input logic [31:0] exp, input logic eresp,
                     input logic [1:0] ew, input string nm);
    int   n = 0;
    logic ok = 1'b0;
    HSEL   = act;
    HTRANS = act ? 2'b10 : 2'b00;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    if (act && push) begin
      exp_q.push_back('{chkd, exp, eresp, ew});
      nm_q.push_back(nm);
    end
    while (!ok) begin
      @(negedge HCLK);
      ok = HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
      if (!ok && n > 20) begin
        n_chk++;
        $display("FAIL %s_accept_timeout: got stalled expected accepted", nm);
        ok = 1'b1;
      end
    end
    HWDATA = wd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    bus(1'b1, a, 1'b1, sz, d, 1'b1, 1'b0, '0, 1'b0, 2'd0, $sformatf("wr_%0h", a));
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    bus(1'b1, a, 1'b0, 3'd2, '0, 1'b1, 1'b1, e, 1'b0, 2'd0, nm);
  endtask

  task automatic rd_err(input logic [31:0] a, input string nm);
    bus(1'b1, a, 1'b0, 3'd2, '0, 1'b1, 1'b0, '0, 1'b1, 2'd1, nm);
  endtask

  task automatic wr_err(input logic [31:0] a, input logic [31:0] d, input string nm);
    bus(1'b1, a, 1'b1, 3'd2, d, 1'b1, 1'b0, '0, 1'b1, 2'd1, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, '0, 1'b0, 3'd2, '0, 1'b0, 1'b0, '0, 1'b0, 2'd0, "idle");
  endtask

  // Monitor: completes data phases and compares against the queue.
  initial begin : monitor
    int    waits = 0;
    logic  dp_act = 1'b0;
    logic  acc_now;
    exp_t  e;
    string nm;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dp_act = 1'b0;
        waits  = 0;
      end else begin
        acc_now = HSEL && HREADYOUT && HTRANS[1];
        if (dp_act) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_xfer: got data phase expected none");
            dp_act = 1'b0;
          end else if (!HREADYOUT) begin
            waits++;
            check({nm_q[0], "_stall_resp"}, 32'(HRESP), 32'(exp_q[0].resp));
          end else begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            check({nm, "_resp"}, 32'(HRESP), 32'(e.resp));
            check({nm, "_waits"}, waits, 32'(e.waits));
            if (e.chk_data) check({nm, "_data"}, HRDATA, e.data);
            waits  = 0;
            dp_act = 1'b0;
          end
        end
        if (!dp_act) dp_act = acc_now;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    tb_oe  = {NP{1'b1}};
    tb_oe[7:0] = 8'h00;
    tb_val = '0;
    tb_val[31:8] = 24'h5A5A5A;

    // Power-on reset
    repeat (3) @(posedge HCLK);
    #1;
    check("por_hreadyout", 32'(HREADYOUT), 32'd1);
    check("por_hresp", 32'(HRESP), 32'd0);
    check("por_irq", 32'(irq), 32'd0);
    check("por_hrdata", HRDATA, 32'd0);
    HRESET = 1'b0;

    // T1: load state, then reset in the middle of ERR1
    wr(32'h00, 32'hFFFF_FFFF, 3'd2);
    wr(32'h04, 32'h0000_00FF, 3'd2);
    wr(32'h74, 32'hFFFF_FFFF, 3'd2);
    rd(32'h74, 32'hFFFF_FFFF, "t1_rise3_pre");
    bus(1'b1, 32'h80, 1'b0, 3'd2, '0, 1'b0, 1'b0, '0, 1'b1, 2'd1, "t1_err");
    check("t1_err1_hreadyout", 32'(HREADYOUT), 32'd0);
    check("t1_err1_hresp", 32'(HRESP), 32'd1);
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    #1;
    check("t1_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("t1_rst_hresp", 32'(HRESP), 32'd0);
    check("t1_rst_irq", 32'(irq), 32'd0);
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    rd(32'h00, 32'h0, "t1_out0");
    rd(32'h04, 32'h0, "t1_dir0");
    rd(32'h74, 32'h0, "t1_rise3");
    rd(32'h7C, 32'h0, "t1_stat3");

    // T2: direction and output, then synchronised input latency
    wr(32'h04, 32'h0000_00FF, 3'd2);
    idle(3);
    wr(32'h00, 32'hA5A5_A5A5, 3'd2);
    rd(32'h08, 32'h5A5A_5A00, "t2_in_c0");
    rd(32'h08, 32'h5A5A_5A00, "t2_in_c1");
    rd(32'h08, 32'h5A5A_5AA5, "t2_in_c2");
    rd(32'h04, 32'h0000_00FF, "t2_dir0");
    rd(32'h00, 32'hA5A5_A5A5, "t2_out0");
    idle(1);
    check("t2_pins_port0", io_pin[31:0], 32'h5A5A_5AA5);

    // T3: atomics and byte lanes on port 1
    wr(32'h20, 32'h0000_000F, 3'd2);
    wr(32'h2C, 32'h0000_00F0, 3'd2);
    wr(32'h30, 32'h0000_0003, 3'd2);
    rd(32'h20, 32'h0000_00FC, "t3_out1_atomic");
    wr(32'h21, 32'h0000_1200, 3'd0);
    rd(32'h20, 32'h0000_12FC, "t3_out1_byte");
    wr(32'h22, 32'hBEEF_0000, 3'd1);
    rd(32'h20, 32'hBEEF_12FC, "t3_out1_half");
    rd(32'h2C, 32'h0, "t3_set_reads0");
    rd(32'h30, 32'h0, "t3_clr_reads0");

    // T4: edge interrupts on port 2 (pins 67 = bit 3, 69 = bit 5)
    wr(32'h54, 32'h0000_0008, 3'd2);
    wr(32'h58, 32'h0000_0020, 3'd2);
    idle(3);
    tb_val[67] = 1'b1;
    @(posedge HCLK);
    #1;
    @(posedge HCLK);
    #1;
    check("t4_irq_before", 32'(irq), 32'h0);
    @(posedge HCLK);
    #1;
    check("t4_irq_after3", 32'(irq), 32'h4);
    rd(32'h5C, 32'h8, "t4_stat_rise");
    wr(32'h5C, 32'h8, 3'd2);
    idle(1);
    check("t4_irq_w1c", 32'(irq), 32'h0);
    tb_val[67] = 1'b0;
    idle(5);
    rd(32'h5C, 32'h0, "t4_fall_no_en");
    tb_val[69] = 1'b1;
    idle(5);
    rd(32'h5C, 32'h0, "t4_rise_no_en");
    tb_val[69] = 1'b0;
    idle(5);
    rd(32'h5C, 32'h20, "t4_stat_fall");
    check("t4_irq_fall", 32'(irq), 32'h4);
    wr(32'h58, 32'h0, 3'd2);
    rd(32'h5C, 32'h20, "t4_sticky");
    wr(32'h5D, 32'h0000_FF00, 3'd0);
    rd(32'h5C, 32'h20, "t4_w1c_wrong_lane");
    wr(32'h5C, 32'h20, 3'd2);
    rd(32'h5C, 32'h0, "t4_w1c_clear");

    // T5: W1C in the same cycle a new enabled edge sets the bit
    tb_val[67] = 1'b1;
    idle(5);
    rd(32'h5C, 32'h8, "t5_pre_set");
    tb_val[67] = 1'b0;
    idle(4);
    tb_val[67] = 1'b1;
    idle(1);
    wr(32'h5C, 32'h8, 3'd2);
    rd(32'h5C, 32'h8, "t5_set_wins");
    wr(32'h5C, 32'h8, 3'd2);
    rd(32'h5C, 32'h0, "t5_clear");
    idle(1);
    check("t5_irq_clear", 32'(irq), 32'h0);

    // T6: decode errors, back to back, then a zero-wait OKAY
    rd_err(32'h80, "t6_rd_port4");
    wr_err(32'h80, 32'hFFFF_FFFF, "t6_wr_port4");
    wr_err(32'h100, 32'hDEAD_BEEF, "t6_wr_hiaddr");
    rd(32'h00, 32'hA5A5_A5A5, "t6_ok_after_err");
    rd(32'h04, 32'h0000_00FF, "t6_dir0_intact");
    rd(32'h20, 32'hBEEF_12FC, "t6_out1_intact");

    idle(3);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
